// File: rtl/cave_video_pkg.sv
// ---------------------------------------------------------------------------
// cave_video_pkg
//   Shared definitions for the video pixel path: frame geometry, the DDR
//   word size, the derived frame length in 64-bit words, the DMA state
//   encoding and a helper that sizes the next read burst.
// ---------------------------------------------------------------------------
package cave_video_pkg;

   localparam int FRAME_WIDTH    = 320;
   localparam int FRAME_HEIGHT   = 240;
   localparam int BITS_PER_PIXEL = 16;
   localparam int DDR_WORD_BYTES = 8;

   // 64-bit DDR words needed to hold one frame (four 16-bit pixels per word)
   localparam int FRAME_WORDS =
      (FRAME_WIDTH * FRAME_HEIGHT * BITS_PER_PIXEL) / (DDR_WORD_BYTES * 8);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_ROOM = 2'd1,
      REQ       = 2'd2,
      DATA      = 2'd3
   } dma_state_t;

   // Beats for the next burst: a full burst, or whatever is left of the frame.
   // burst_len is at most 128, so eight bits always hold the result.
   function automatic logic [7:0] burst_beats(input logic [31:0] remaining,
                                              input int unsigned burst_len);
      logic [31:0] w_len;
      w_len = burst_len;
      if (remaining > w_len) begin
         return w_len[7:0];
      end
      return remaining[7:0];
   endfunction

endpackage

// File: rtl/video_dma_if.sv
// ---------------------------------------------------------------------------
// video_dma_if
//   Bundles the frame-start control, the Avalon-style DDR read port, the
//   pixel FIFO write port and the status/debug outputs of video_dma.
//
//   Handshakes:
//     * DDR request: ddr_rd with ddr_addr/ddr_burst_count is a request that
//       stays asserted and stable until a cycle where ddr_wait_req is low;
//       that cycle is the acceptance. Read data comes back as ddr_valid
//       beats with no backpressure.
//     * Pixel port: pixel_valid is a write strobe with no ready; pixel_ready
//       only says the FIFO has room for a whole burst and is looked at
//       before a burst is requested.
//
//   Modports:
//     master - the DMA engine (drives requests, pixels and status)
//     slave  - the environment (arbiter, memory, FIFO, frame timing)
// ---------------------------------------------------------------------------
interface video_dma_if;
   import cave_video_pkg::*;

   logic        start;
   logic        ddr_rd;
   logic [31:0] ddr_addr;
   logic [7:0]  ddr_burst_count;
   logic        ddr_wait_req;
   logic        ddr_valid;
   logic [63:0] ddr_dout;
   logic        pixel_ready;
   logic        pixel_valid;
   logic [63:0] pixel_data;
   logic        busy;
   logic        done;
   logic        overrun;
   dma_state_t  dbg_state;

   modport master (
      input  start, ddr_wait_req, ddr_valid, ddr_dout, pixel_ready,
      output ddr_rd, ddr_addr, ddr_burst_count, pixel_valid, pixel_data,
             busy, done, overrun, dbg_state
   );

   modport slave (
      output start, ddr_wait_req, ddr_valid, ddr_dout, pixel_ready,
      input  ddr_rd, ddr_addr, ddr_burst_count, pixel_valid, pixel_data,
             busy, done, overrun, dbg_state
   );

endinterface

// File: rtl/video_dma.sv
// ---------------------------------------------------------------------------
// video_dma
//   Producer end of the video pixel FIFO. On each frame start it walks the
//   frame buffer in DDR with read bursts of up to BURST_LEN beats and copies
//   every returned 64-bit word onto the FIFO write port one cycle later.
//   Only one burst is outstanding at a time.
//
//   Ports:
//     clock  - fast system clock
//     reset  - synchronous, active-high reset
//     bus    - video_dma_if.master: start, DDR read port, pixel port,
//              busy/done/overrun status and the FSM state for debug
//
//   Parameters:
//     BASE_ADDR   - byte address of the frame buffer (8-byte aligned)
//     FRAME_WORDS - 64-bit words per frame
//     BURST_LEN   - maximum beats per burst (1..128)
// ---------------------------------------------------------------------------
module video_dma #(
   parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
   parameter int unsigned FRAME_WORDS = cave_video_pkg::FRAME_WORDS,
   parameter int unsigned BURST_LEN   = 16
) (
   input  logic        clock,
   input  logic        reset,
   video_dma_if.master bus
);
   import cave_video_pkg::*;

   localparam int RW = $clog2(FRAME_WORDS + 1);

   dma_state_t      r_state;
   logic [31:0]     r_addr;        // address of the next burst to issue
   logic [RW-1:0]   r_remaining;   // words of the frame still to arrive
   logic [7:0]      r_beats;       // beats still to arrive in this burst
   logic            r_ddr_rd;
   logic [31:0]     r_ddr_addr;
   logic [7:0]      r_ddr_burst;
   logic            r_pixel_valid;
   logic [63:0]     r_pixel_data;
   logic            r_busy;
   logic            r_done;
   logic            r_overrun;

   logic [31:0]     w_rem32;
   logic [7:0]      w_next_burst;
   logic            w_last_of_burst;
   logic            w_last_of_frame;

   assign w_rem32         = 32'(r_remaining);
   assign w_next_burst    = burst_beats(w_rem32, BURST_LEN);
   assign w_last_of_burst = (r_beats == 8'd1);
   assign w_last_of_frame = (r_remaining == RW'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_addr        <= BASE_ADDR;
         r_remaining   <= '0;
         r_beats       <= '0;
         r_ddr_rd      <= 1'b0;
         r_ddr_addr    <= '0;
         r_ddr_burst   <= '0;
         r_pixel_valid <= 1'b0;
         r_pixel_data  <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_overrun     <= 1'b0;
      end else begin
         r_pixel_valid <= 1'b0;
         r_done        <= 1'b0;
         r_overrun     <= 1'b0;

         // busy stays up through the done cycle and drops right after it,
         // so a start landing on the done cycle is still an overrun.
         if (r_done) begin
            r_busy <= 1'b0;
         end
         if (bus.start && r_busy) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (bus.start && !r_busy) begin
                  r_addr      <= BASE_ADDR;
                  r_remaining <= RW'(FRAME_WORDS);
                  r_busy      <= 1'b1;
                  r_state     <= WAIT_ROOM;
               end
            end

            WAIT_ROOM: begin
               // FIFO room is only checked here; a granted burst always
               // runs to completion.
               if (bus.pixel_ready) begin
                  r_ddr_rd    <= 1'b1;
                  r_ddr_addr  <= r_addr;
                  r_ddr_burst <= w_next_burst;
                  r_state     <= REQ;
               end
            end

            REQ: begin
               // Request held stable until the arbiter drops wait_req.
               // Any ddr_valid seen here is a protocol error and ignored.
               if (!bus.ddr_wait_req) begin
                  r_ddr_rd <= 1'b0;
                  r_beats  <= r_ddr_burst;
                  r_state  <= DATA;
               end
            end

            DATA: begin
               if (bus.ddr_valid) begin
                  r_pixel_valid <= 1'b1;
                  r_pixel_data  <= bus.ddr_dout;
                  r_beats       <= r_beats - 8'd1;
                  r_remaining   <= r_remaining - RW'(1);
                  if (w_last_of_burst) begin
                     if (w_last_of_frame) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                     end else begin
                        // advance by burst beats * 8 bytes; wraps at 2^32
                        r_addr  <= r_addr + {21'd0, r_ddr_burst, 3'd0};
                        r_state <= WAIT_ROOM;
                     end
                  end
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ddr_rd          = r_ddr_rd;
   assign bus.ddr_addr        = r_ddr_addr;
   assign bus.ddr_burst_count = r_ddr_burst;
   assign bus.pixel_valid     = r_pixel_valid;
   assign bus.pixel_data      = r_pixel_data;
   assign bus.busy            = r_busy;
   assign bus.done            = r_done;
   assign bus.overrun         = r_overrun;
   assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_video_dma.sv
// ---------------------------------------------------------------------------
// tb_video_dma
//   Directed bench for video_dma. dut0 runs a 40-word frame against a DDR
//   model with programmable stalls; dut1 runs the default full frame.
//   Returned DDR words are {addr, ~addr}, so pixel k of a frame must carry
//   {BASE + 8k, ~(BASE + 8k)}.
// ---------------------------------------------------------------------------
module tb_video_dma;
   import cave_video_pkg::*;

   localparam logic [31:0] BASE        = 32'h0010_0000;
   localparam int          SMALL_WORDS = 40;

   logic clk = 1'b0;
   logic rst;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   video_dma_if bus0 ();
   video_dma_if bus1 ();

   video_dma #(.BASE_ADDR(BASE), .FRAME_WORDS(SMALL_WORDS), .BURST_LEN(16)) dut0 (
      .clock (clk),
      .reset (rst),
      .bus   (bus0)
   );

   video_dma #(.BASE_ADDR(BASE)) dut1 (
      .clock (clk),
      .reset (rst),
      .bus   (bus1)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- dut0 DDR model state and request log ----------------
   int          m_wait_arm    = 0;
   bit          m_hold        = 1'b0;
   int          m_pause_after = 0;
   int          m_left        = 0;
   int          m_idx         = 0;
   logic [31:0] m_addr        = '0;
   bit          m_rd_prev     = 1'b0;
   int          m_rd_len      = 0;
   bit          m_stable      = 1'b1;
   int          m_rd_start    = 0;
   logic [31:0] m_first_addr  = '0;
   logic [7:0]  m_first_cnt   = '0;

   logic [31:0] req_addr_q[$];
   logic [7:0]  req_cnt_q[$];
   int          req_len_q[$];
   bit          req_stable_q[$];
   int          req_start_q[$];

   // ---------------- dut0 pixel monitor ----------------
   int          mon_beats        = 0;
   logic [63:0] mon_data_q[$];
   int          mon_done_cnt     = 0;
   int          mon_done_beat    = 0;
   bit          mon_busy_at_done = 1'b0;
   bit          mon_busy_after   = 1'b1;
   bit          mon_done_prev    = 1'b0;
   int          mon_ovr_cycles   = 0;

   // ---------------- dut1 full-frame model ----------------
   int          f_left = 0, f_idx = 0, f_bursts = 0, f_beats = 0;
   int          f_done = 0, f_addr_err = 0, f_data_err = 0;
   logic [31:0] f_addr = '0, f_last_addr = '0;

   function automatic logic [63:0] exp_word(input int k);
      logic [31:0] a;
      a = BASE + 32'(k * 8);
      return {a, ~a};
   endfunction

   // DDR model for dut0: drives inputs on the falling edge
   initial begin
      logic [31:0] a;
      bus0.ddr_wait_req = 1'b0;
      bus0.ddr_valid    = 1'b0;
      bus0.ddr_dout     = '0;
      forever begin
         @(negedge clk);
         if (m_left > 0 && !(m_hold && m_idx >= m_pause_after)) begin
            a = m_addr + 32'(m_idx * 8);
            bus0.ddr_valid = 1'b1;
            bus0.ddr_dout  = {a, ~a};
            m_idx++;
            m_left--;
         end else begin
            bus0.ddr_valid = 1'b0;
            bus0.ddr_dout  = '0;
         end
         if (bus0.ddr_rd === 1'b1) begin
            if (!m_rd_prev) begin
               m_rd_start   = cyc;
               m_rd_len     = 0;
               m_stable     = 1'b1;
               m_first_addr = bus0.ddr_addr;
               m_first_cnt  = bus0.ddr_burst_count;
            end else if (bus0.ddr_addr !== m_first_addr ||
                         bus0.ddr_burst_count !== m_first_cnt) begin
               m_stable = 1'b0;
            end
            m_rd_len++;
            bus0.ddr_wait_req = (m_wait_arm > 0);
            if (m_wait_arm > 0) m_wait_arm--;
            if (!bus0.ddr_wait_req) begin
               req_addr_q.push_back(bus0.ddr_addr);
               req_cnt_q.push_back(bus0.ddr_burst_count);
               req_len_q.push_back(m_rd_len);
               req_stable_q.push_back(m_stable);
               req_start_q.push_back(m_rd_start);
               m_addr = bus0.ddr_addr;
               m_left = int'(bus0.ddr_burst_count);
               m_idx  = 0;
            end
         end else begin
            bus0.ddr_wait_req = 1'b0;
         end
         m_rd_prev = (bus0.ddr_rd === 1'b1);
      end
   end

   // pixel monitor for dut0
   initial begin
      forever begin
         @(negedge clk);
         if (mon_done_prev) mon_busy_after = bus0.busy;
         mon_done_prev = (bus0.done === 1'b1);
         if (bus0.pixel_valid === 1'b1) begin
            mon_beats++;
            mon_data_q.push_back(bus0.pixel_data);
         end
         if (bus0.done === 1'b1) begin
            mon_done_cnt++;
            mon_done_beat    = (bus0.pixel_valid === 1'b1) ? mon_beats : -1;
            mon_busy_at_done = bus0.busy;
         end
         if (bus0.overrun === 1'b1) mon_ovr_cycles++;
      end
   end

   // zero-wait DDR model and monitor for dut1
   initial begin
      logic [31:0] a;
      bus1.ddr_wait_req = 1'b0;
      bus1.ddr_valid    = 1'b0;
      bus1.ddr_dout     = '0;
      forever begin
         @(negedge clk);
         if (f_left > 0) begin
            a = f_addr + 32'(f_idx * 8);
            bus1.ddr_valid = 1'b1;
            bus1.ddr_dout  = {a, ~a};
            f_idx++;
            f_left--;
         end else begin
            bus1.ddr_valid = 1'b0;
         end
         if (bus1.ddr_rd === 1'b1) begin
            if (bus1.ddr_addr !== BASE + 32'(f_bursts * 128)) f_addr_err++;
            f_bursts++;
            f_last_addr = bus1.ddr_addr;
            f_addr      = bus1.ddr_addr;
            f_left      = int'(bus1.ddr_burst_count);
            f_idx       = 0;
         end
         if (bus1.pixel_valid === 1'b1) begin
            a = BASE + 32'(f_beats * 8);
            if (bus1.pixel_data !== {a, ~a}) f_data_err++;
            f_beats++;
         end
         if (bus1.done === 1'b1) f_done++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      req_addr_q.delete();
      req_cnt_q.delete();
      req_len_q.delete();
      req_stable_q.delete();
      req_start_q.delete();
      mon_data_q.delete();
      mon_beats      = 0;
      mon_done_cnt   = 0;
      mon_done_beat  = 0;
      mon_busy_after = 1'b1;
      mon_ovr_cycles = 0;
   endtask

   task automatic pulse_start0();
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
   endtask

   task automatic wait_done0(input int target, input int budget, output bit timed_out);
      int k;
      k = 0;
      while (mon_done_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      timed_out = (mon_done_cnt < target);
      repeat (3) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [108:0] obs;
      repeat (3) @(negedge clk);
      obs = {bus0.ddr_rd, bus0.ddr_addr, bus0.ddr_burst_count, bus0.pixel_valid,
             bus0.pixel_data, bus0.busy, bus0.done, bus0.overrun};
      n_checks++;
      if (obs !== '0) $display("FAIL reset_outputs: got %h expected 0", obs);
      else n_pass++;
      n_checks++;
      if (bus0.dbg_state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", bus0.dbg_state, IDLE);
      else n_pass++;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus0.busy, bus0.ddr_rd} !== 2'b00) $display("FAIL idle_after_reset: busy/rd got %b expected 00", {bus0.busy, bus0.ddr_rd});
      else n_pass++;
   endtask

   task automatic test_basic_frame();
      bit to;
      int bad;
      logic [31:0] ea;
      logic [7:0]  ec;
      clear_logs();
      bus0.pixel_ready = 1'b1;
      pulse_start0();
      n_checks++;
      if (bus0.busy !== 1'b1) $display("FAIL basic_busy_rise: got %b expected 1", bus0.busy);
      else n_pass++;
      wait_done0(1, 300, to);
      n_checks++;
      if (to) $display("FAIL basic_timeout: done count %0d expected 1", mon_done_cnt);
      else n_pass++;
      n_checks++;
      if (req_addr_q.size() != 3) $display("FAIL basic_burst_count: got %0d expected 3", req_addr_q.size());
      else n_pass++;
      for (int b = 0; b < 3 && b < req_addr_q.size(); b++) begin
         ea = BASE + 32'(b * 128);
         ec = (b == 2) ? 8'd8 : 8'd16;
         n_checks++;
         if (req_addr_q[b] !== ea || req_cnt_q[b] !== ec)
            $display("FAIL basic_burst%0d: got (%h,%0d) expected (%h,%0d)", b, req_addr_q[b], req_cnt_q[b], ea, ec);
         else n_pass++;
      end
      n_checks++;
      if (mon_beats != SMALL_WORDS) $display("FAIL basic_beats: got %0d expected %0d", mon_beats, SMALL_WORDS);
      else n_pass++;
      bad = -1;
      for (int k = 0; k < mon_data_q.size(); k++)
         if (bad < 0 && mon_data_q[k] !== exp_word(k)) bad = k;
      n_checks++;
      if (bad >= 0) $display("FAIL basic_data: beat %0d got %h expected %h", bad, mon_data_q[bad], exp_word(bad));
      else n_pass++;
      n_checks++;
      if (mon_done_beat != SMALL_WORDS) $display("FAIL basic_done_beat: got %0d expected %0d", mon_done_beat, SMALL_WORDS);
      else n_pass++;
      n_checks++;
      if ({mon_busy_at_done, mon_busy_after} !== 2'b10)
         $display("FAIL basic_busy_fall: busy at/after done got %b expected 10", {mon_busy_at_done, mon_busy_after});
      else n_pass++;
   endtask

   task automatic test_wait_req();
      bit to;
      clear_logs();
      m_wait_arm = 5;
      pulse_start0();
      wait_done0(1, 300, to);
      n_checks++;
      if (to || req_addr_q.size() != 3) $display("FAIL wait_bursts: got %0d bursts, timeout %b, expected 3", req_addr_q.size(), to);
      else n_pass++;
      n_checks++;
      if (req_len_q.size() < 1 || req_len_q[0] != 6 || req_stable_q[0] !== 1'b1)
         $display("FAIL wait_hold: rd cycles %0d stable %b expected 6 1",
                  (req_len_q.size() > 0) ? req_len_q[0] : -1, (req_stable_q.size() > 0) ? req_stable_q[0] : 1'b0);
      else n_pass++;
      n_checks++;
      if (req_addr_q.size() < 2 || req_addr_q[0] !== BASE || req_addr_q[1] !== BASE + 32'd128)
         $display("FAIL wait_addrs: got %h %h expected %h %h",
                  (req_addr_q.size() > 0) ? req_addr_q[0] : 32'hx, (req_addr_q.size() > 1) ? req_addr_q[1] : 32'hx,
                  BASE, BASE + 32'd128);
      else n_pass++;
      n_checks++;
      if (mon_beats != SMALL_WORDS) $display("FAIL wait_beats: got %0d expected %0d", mon_beats, SMALL_WORDS);
      else n_pass++;
   endtask

   task automatic test_pixel_ready();
      bit to;
      int k, bad, beats_at_raise, reqs_at_raise, c_rise;
      clear_logs();
      bus0.pixel_ready = 1'b1;
      pulse_start0();
      k = 0;
      while (req_addr_q.size() < 1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      bus0.pixel_ready = 1'b0;
      repeat (20) @(negedge clk);
      beats_at_raise   = mon_beats;
      reqs_at_raise    = req_addr_q.size();
      c_rise           = int'(cyc);
      bus0.pixel_ready = 1'b1;
      wait_done0(1, 300, to);
      n_checks++;
      if (reqs_at_raise != 1 || beats_at_raise != 16)
         $display("FAIL ready_stall: reqs %0d beats %0d at raise expected 1 16", reqs_at_raise, beats_at_raise);
      else n_pass++;
      n_checks++;
      if (req_start_q.size() < 2 || req_start_q[1] != c_rise + 1)
         $display("FAIL ready_resume: burst2 rd cycle %0d expected %0d",
                  (req_start_q.size() > 1) ? req_start_q[1] : -1, c_rise + 1);
      else n_pass++;
      bad = -1;
      for (int j = 0; j < mon_data_q.size(); j++)
         if (bad < 0 && mon_data_q[j] !== exp_word(j)) bad = j;
      n_checks++;
      if (to || mon_beats != SMALL_WORDS || bad >= 0)
         $display("FAIL ready_frame: beats %0d first bad %0d timeout %b expected 40 -1 0", mon_beats, bad, to);
      else n_pass++;
   endtask

   task automatic test_overrun();
      bit to;
      int k;
      clear_logs();
      pulse_start0();
      k = 0;
      while (mon_beats < 10 && k < 200) begin
         @(negedge clk);
         k++;
      end
      pulse_start0();
      wait_done0(1, 300, to);
      n_checks++;
      if (mon_ovr_cycles != 1) $display("FAIL overrun_pulse: got %0d cycles expected 1", mon_ovr_cycles);
      else n_pass++;
      n_checks++;
      if (to || mon_beats != SMALL_WORDS || mon_done_cnt != 1 || req_addr_q.size() != 3)
         $display("FAIL overrun_frame: beats %0d done %0d bursts %0d expected 40 1 3", mon_beats, mon_done_cnt, req_addr_q.size());
      else n_pass++;

      // start coinciding with the done pulse
      clear_logs();
      pulse_start0();
      k = 0;
      while (bus0.done !== 1'b1 && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (bus0.done !== 1'b1) $display("FAIL done_start_timeout: done got %b expected 1", bus0.done);
      else n_pass++;
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      n_checks++;
      if ({bus0.overrun, bus0.busy} !== 2'b10)
         $display("FAIL done_start_overrun: overrun/busy got %b expected 10", {bus0.overrun, bus0.busy});
      else n_pass++;
      repeat (10) @(negedge clk);
      n_checks++;
      if (req_addr_q.size() != 3 || bus0.dbg_state !== IDLE || bus0.busy !== 1'b0)
         $display("FAIL done_start_idle: bursts %0d state %0d busy %b expected 3 0 0",
                  req_addr_q.size(), bus0.dbg_state, bus0.busy);
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      bit to;
      int k, b0, bad;
      logic [108:0] obs;
      clear_logs();
      m_pause_after = 5;
      m_hold        = 1'b1;
      pulse_start0();
      k = 0;
      while (mon_beats < 5 && k < 100) begin
         @(negedge clk);
         k++;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      obs = {bus0.ddr_rd, bus0.ddr_addr, bus0.ddr_burst_count, bus0.pixel_valid,
             bus0.pixel_data, bus0.busy, bus0.done, bus0.overrun};
      n_checks++;
      if (obs !== '0 || bus0.dbg_state !== IDLE)
         $display("FAIL midreset_outputs: got %h state %0d expected 0 0", obs, bus0.dbg_state);
      else n_pass++;
      rst    = 1'b0;
      b0     = mon_beats;
      m_hold = 1'b0;
      repeat (20) @(negedge clk);
      n_checks++;
      if (b0 != 5 || mon_beats != b0 || m_left != 0)
         $display("FAIL midreset_stale: beats before %0d after %0d undelivered %0d expected 5 5 0", b0, mon_beats, m_left);
      else n_pass++;
      n_checks++;
      if (req_addr_q.size() != 1 || bus0.busy !== 1'b0)
         $display("FAIL midreset_quiet: bursts %0d busy %b expected 1 0", req_addr_q.size(), bus0.busy);
      else n_pass++;

      clear_logs();
      pulse_start0();
      wait_done0(1, 300, to);
      bad = -1;
      for (int j = 0; j < mon_data_q.size(); j++)
         if (bad < 0 && mon_data_q[j] !== exp_word(j)) bad = j;
      n_checks++;
      if (to || mon_beats != SMALL_WORDS || bad >= 0 || mon_done_cnt != 1)
         $display("FAIL midreset_frame: beats %0d first bad %0d done %0d expected 40 -1 1", mon_beats, bad, mon_done_cnt);
      else n_pass++;
      n_checks++;
      if (req_addr_q.size() != 3 || req_addr_q[2] !== BASE + 32'd256 || req_cnt_q[2] !== 8'd8)
         $display("FAIL midreset_last_burst: bursts %0d expected 3 ending (%h,8)", req_addr_q.size(), BASE + 32'd256);
      else n_pass++;
   endtask

   task automatic test_full_frame();
      int k;
      logic [31:0] exp_last;
      exp_last = BASE + 32'(19200 * 8 - 128);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      k = 0;
      while (f_done < 1 && k < 30000) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (f_done != 1) $display("FAIL full_done: got %0d expected 1", f_done);
      else n_pass++;
      n_checks++;
      if (f_bursts != 1200 || f_addr_err != 0)
         $display("FAIL full_bursts: got %0d bursts, %0d bad addresses expected 1200 0", f_bursts, f_addr_err);
      else n_pass++;
      n_checks++;
      if (f_beats != 19200 || f_data_err != 0)
         $display("FAIL full_beats: got %0d beats, %0d bad words expected 19200 0", f_beats, f_data_err);
      else n_pass++;
      n_checks++;
      if (f_last_addr !== exp_last) $display("FAIL full_last_addr: got %h expected %h", f_last_addr, exp_last);
      else n_pass++;
      n_checks++;
      if (bus1.busy !== 1'b0) $display("FAIL full_busy: got %b expected 0", bus1.busy);
      else n_pass++;
   endtask

   initial begin
      rst              = 1'b1;
      bus0.start       = 1'b0;
      bus0.pixel_ready = 1'b0;
      bus1.start       = 1'b0;
      bus1.pixel_ready = 1'b1;
      test_reset();
      test_basic_frame();
      test_wait_req();
      test_pixel_ready();
      test_overrun();
      test_reset_mid_burst();
      test_full_frame();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
